// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared FSM states, reset-cause codes and counter sizing for rst_seq
package rst_seq_pkg;
  typedef enum logic [1:0] {HOLD, STAGE, RUN} state_e;
  localparam logic [1:0] CAUSE_EXT  = 2'd0;
  localparam logic [1:0] CAUSE_LOCK = 2'd1;
  localparam logic [1:0] CAUSE_BTN  = 2'd2;
  localparam logic [1:0] CAUSE_SW   = 2'd3;
  function automatic int cnt_width(input int hold, input int gap);
    return $clog2((hold > gap ? hold : gap) + 1);
  endfunction
endpackage

// File: rtl/rst_seq_btn_debounce.sv
// btn_debounce: synchronises an active-low button and emits one press pulse per accepted press
module btn_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_x_i,
  input  logic btn_x_i,
  output logic press_o
);
  localparam int DW = $clog2(DEBOUNCE + 1);
  logic s1_q, s2_q, armed_q, press_q;
  logic [DW-1:0] run_q;
  // armed_q only returns after a sampled high, so a held button fires once
  always_ff @(posedge clk) begin
    if (!rst_x_i) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      armed_q <= 1'b0;
      run_q <= '0;
      press_q <= 1'b0;
    end else begin
      s1_q <= btn_x_i;
      s2_q <= s1_q;
      press_q <= 1'b0;
      if (s2_q) begin
        run_q <= '0;
        armed_q <= 1'b1;
      end else if (armed_q) begin
        if (run_q == DW'(DEBOUNCE - 1)) begin
          press_q <= 1'b1;
          armed_q <= 1'b0;
          run_q <= '0;
        end else run_q <= run_q + 1'b1;
      end
    end
  end
  assign press_o = press_q;
endmodule

// File: rtl/rst_seq.sv
// rst_seq: holds NCH reset domains, releases them in order, re-asserts on lock loss/button/software
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int HOLD_CYCLES = 128,
  parameter int GAP_CYCLES  = 16,
  parameter int DEBOUNCE    = 4
) (
  input  logic           CLK,
  input  logic           RST_X_I,
  input  logic           LOCKED,
  input  logic           BTN_X,
  input  logic           SWRST_REQ,
  output logic [NCH-1:0] RST_X_O,
  output logic           DONE,
  output logic [1:0]     CAUSE
);
  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q;
  logic [NCH-1:0] rst_q;
  logic done_q;
  logic [1:0] cause_q;
  logic press, evt;
  logic [1:0] evt_cause;
  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_btn (
    .clk(CLK),
    .rst_x_i(RST_X_I),
    .btn_x_i(BTN_X),
    .press_o(press)
  );
  always_comb begin
    evt = !LOCKED || press || SWRST_REQ;
    evt_cause = !LOCKED ? CAUSE_LOCK : press ? CAUSE_BTN : CAUSE_SW;
  end
  always_ff @(posedge CLK) begin
    if (!RST_X_I) begin
      state_q <= HOLD;
      cnt_q <= '0;
      idx_q <= '0;
      rst_q <= '0;
      done_q <= 1'b0;
      cause_q <= CAUSE_EXT;
    end else if (evt) begin
      state_q <= HOLD;
      cnt_q <= '0;
      rst_q <= '0;
      done_q <= 1'b0;
      cause_q <= evt_cause;
    end else begin
      case (state_q)
        HOLD:
          if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
            rst_q[0] <= 1'b1;
            cnt_q <= '0;
            idx_q <= IW'(1);
            done_q <= NCH == 1;
            state_q <= NCH == 1 ? RUN : STAGE;
          end else cnt_q <= cnt_q + 1'b1;
        STAGE:
          if (cnt_q == CW'(GAP_CYCLES - 1)) begin
            rst_q <= rst_q | (NCH'(1) << idx_q);
            cnt_q <= '0;
            idx_q <= idx_q + 1'b1;
            if (idx_q == IW'(NCH - 1)) begin
              done_q <= 1'b1;
              state_q <= RUN;
            end
          end else cnt_q <= cnt_q + 1'b1;
        default: ;
      endcase
    end
  end
  assign RST_X_O = rst_q;
  assign DONE = done_q;
  assign CAUSE = cause_q;
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed and random stimulus against a count-since-last-event reference model
module tb_rst_seq;
  localparam int NCH = 3, HOLD = 128, GAP = 16, DEB = 4;
  logic CLK = 1'b0;
  logic RST_X_I, LOCKED, BTN_X, SWRST_REQ;
  logic [NCH-1:0] RST_X_O;
  logic DONE;
  logic [1:0] CAUSE;
  int checks = 0, failures = 0;
  int m_cnt = 0, m_run = 0, blow = 0;
  logic [1:0] m_cause = 2'd0;
  logic m_press = 1'b0;
  logic q_hist[$];

  always #5 CLK = ~CLK;

  rst_seq #(.NCH(NCH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .DEBOUNCE(DEB)) dut (
    .CLK(CLK),
    .RST_X_I(RST_X_I),
    .LOCKED(LOCKED),
    .BTN_X(BTN_X),
    .SWRST_REQ(SWRST_REQ),
    .RST_X_O(RST_X_O),
    .DONE(DONE),
    .CAUSE(CAUSE)
  );

  // Domain k is released once HOLD + k*GAP event-free qualified edges have elapsed
  function automatic logic [NCH-1:0] exp_rst();
    logic [NCH-1:0] e;
    for (int k = 0; k < NCH; k++) e[k] = m_cnt >= HOLD + k * GAP;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Button acceptance: delayed sample (two edges late) low for DEB consecutive edges
  task automatic model_edge(input logic r, input logic l, input logic b, input logic s);
    logic smp;
    if (!r) begin
      m_cnt = 0;
      m_cause = 2'd0;
      m_press = 1'b0;
      m_run = 0;
      q_hist = '{1'b1, 1'b1};
    end else begin
      if (!l || m_press || s) begin
        m_cnt = 0;
        m_cause = !l ? 2'd1 : m_press ? 2'd2 : 2'd3;
      end else m_cnt++;
      smp = q_hist.pop_front();
      q_hist.push_back(b);
      m_run = smp ? 0 : m_run + 1;
      m_press = m_run == DEB;
    end
  endtask

  task automatic step(input logic r, input logic l, input logic b, input logic s);
    RST_X_I = r;
    LOCKED = l;
    BTN_X = b;
    SWRST_REQ = s;
    @(posedge CLK);
    model_edge(r, l, b, s);
    #1;
    chk("rst_x_o", 32'(RST_X_O), 32'(exp_rst()));
    chk("done", 32'(DONE), 32'(m_cnt >= HOLD + (NCH - 1) * GAP));
    chk("cause", 32'(CAUSE), 32'(m_cause));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    q_hist = '{1'b1, 1'b1};
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("reset_rst", 32'(RST_X_O), 32'h0);
    chk("reset_done", 32'(DONE), 32'h0);
    // power-up timing
    run(127);
    chk("pu_127", 32'(RST_X_O), 32'h0);
    run(1);
    chk("pu_128", 32'(RST_X_O), 32'h1);
    run(15);
    chk("pu_143", 32'(RST_X_O), 32'h1);
    run(1);
    chk("pu_144", 32'(RST_X_O), 32'h3);
    run(15);
    chk("pu_159_done", 32'(DONE), 32'h0);
    run(1);
    chk("pu_160", 32'(RST_X_O), 32'h7);
    chk("pu_160_done", 32'(DONE), 32'h1);
    chk("pu_cause", 32'(CAUSE), 32'h0);
    // lock loss in RUN
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("lock_drop", 32'(RST_X_O), 32'h0);
    chk("lock_cause", 32'(CAUSE), 32'h1);
    run(127);
    chk("lock_127", 32'(RST_X_O), 32'h0);
    run(1);
    chk("lock_128", 32'(RST_X_O), 32'h1);
    run(40);
    // lock loss at HOLD count 100 restarts the full hold
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("sw_cause", 32'(CAUSE), 32'h3);
    run(100);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    run(28);
    chk("hold_no_early", 32'(RST_X_O), 32'h0);
    run(99);
    chk("hold_127", 32'(RST_X_O), 32'h0);
    run(1);
    chk("hold_128", 32'(RST_X_O), 32'h1);
    run(40);
    // software + lock loss together
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("both_cause", 32'(CAUSE), 32'h1);
    run(160);
    chk("both_done", 32'(DONE), 32'h1);
    // short and long button presses
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    run(10);
    chk("btn_short", 32'(RST_X_O), 32'h7);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("btn_long_rst", 32'(RST_X_O), 32'h0);
    chk("btn_long_cause", 32'(CAUSE), 32'h2);
    run(160);
    chk("btn_done", 32'(DONE), 32'h1);
    // master reset mid-STAGE
    step(1'b1, 1'b0, 1'b1, 1'b0);
    run(130);
    chk("stage_mid", 32'(RST_X_O), 32'h1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("ext_rst", 32'(RST_X_O), 32'h0);
    chk("ext_cause", 32'(CAUSE), 32'h0);
    run(160);
    chk("ext_done", 32'(DONE), 32'h1);
    // random rounds: noisy phase then quiet phase
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < int'($urandom_range(20, 200)); i++) begin
        if (blow > 0) blow--;
        else if ($urandom_range(0, 40) == 0) blow = $urandom_range(1, 10);
        step($urandom_range(0, 400) != 0, $urandom_range(0, 150) != 0, blow == 0,
             $urandom_range(0, 150) == 0);
      end
      blow = 0;
      run(170);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
